// File: rtl/uart_command_rx.sv
// ---------------------------------------------------------------------------
// uart_command_rx
//
// This is the receive side of the command UART. It turns 8N1 serial frames on
// rx into bytes. Each byte carries a 3-bit command as {5'd0, command}. The
// command is handed to the control logic through a valid/ack handshake.
// Framing errors, malformed commands and overruns are each reported as a
// one-cycle pulse.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-low reset
//   rx         in   1  serial line, idle high, asynchronous to clk
//   command    out  3  last accepted command, stable while cmd_valid=1
//   cmd_valid  out  1  command holds an unconsumed command
//   cmd_ack    in   1  consumer accepts command (ignored while cmd_valid=0)
//   frame_err  out  1  pulse: stop bit sampled low
//   bad_cmd    out  1  pulse: byte[7:3] != 0, byte discarded
//   overrun    out  1  pulse: good byte arrived while command still pending
//   busy       out  1  receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_command_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [2:0] command,
    output logic       cmd_valid,
    input  logic       cmd_ack,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [CNT_W-1:0]       bit_cnt_s;
    logic [2:0]             bit_idx_r;
    logic [2:0]             bit_idx_s;
    logic [7:0]             shift_r;
    logic [7:0]             shift_s;
    logic                   byte_done_s;
    logic                   frame_err_s;

    logic [2:0]             command_s;
    logic                   cmd_valid_s;
    logic                   bad_cmd_s;
    logic                   overrun_s;

    // Metastability synchroniser for rx; it resets to the idle-high level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs_s = sync_r[SYNC_STAGES-1];

    // Receiver FSM next state: start-bit qualification, bit timing and shifting.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        byte_done_s = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_s   = ST_START;
                    bit_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Re-check at the middle of the start bit. A short low pulse is a glitch.
                if (bit_cnt_r == CNT_HALF) begin
                    if (rxs_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_DATA;
                        bit_cnt_s = '0;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                // The counter starts at mid start bit, so a full bit period lands mid data bit.
                if (bit_cnt_r == CNT_LAST) begin
                    shift_s[bit_idx_r] = rxs_s;
                    bit_cnt_s          = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                // The FSM returns to IDLE at mid stop bit. The half bit that remains
                // lets the FSM catch a start bit that follows with no idle time.
                if (bit_cnt_r == CNT_LAST) begin
                    bit_cnt_s = '0;
                    if (!rxs_s) begin
                        frame_err_s = 1'b1;
                        state_s     = ST_WAIT_IDLE;
                    end else begin
                        byte_done_s = 1'b1;
                        state_s     = ST_IDLE;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = '0;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // Byte evaluation and handshake. Priority order: malformed byte, overrun, load.
    always_comb begin
        command_s   = command;
        cmd_valid_s = cmd_valid;
        bad_cmd_s   = 1'b0;
        overrun_s   = 1'b0;
        if (cmd_valid && cmd_ack) begin
            cmd_valid_s = 1'b0;
        end else begin
            cmd_valid_s = cmd_valid;
        end
        if (byte_done_s) begin
            if (shift_r[7:3] != 5'd0) begin
                bad_cmd_s = 1'b1;
            end else if (cmd_valid && !cmd_ack) begin
                overrun_s = 1'b1;
            end else begin
                // If an ack arrives in the same cycle, the new command replaces the old one with no gap.
                command_s   = shift_r[2:0];
                cmd_valid_s = 1'b1;
            end
        end else begin
            bad_cmd_s = 1'b0;
            overrun_s = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            command   <= 3'd0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            bad_cmd   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            command   <= command_s;
            cmd_valid <= cmd_valid_s;
            frame_err <= frame_err_s;
            bad_cmd   <= bad_cmd_s;
            overrun   <= overrun_s;
            busy      <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_command_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_command_rx
//
// Directed bench for uart_command_rx with CLKS_PER_BIT=16 and SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge. Outputs are read at the same point,
// or counted on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_command_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       cmd_ack;
    logic [2:0] command;
    logic       cmd_valid;
    logic       frame_err;
    logic       bad_cmd;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int fe_cnt    = 0;
    int bc_cnt    = 0;
    int ov_cnt    = 0;
    int multi_cnt = 0;
    int busy_cnt  = 0;
    int vlow_cnt  = 0;

    int fe0, bc0, ov0, busy0, vlow0, rise;

    uart_command_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .command  (command),
        .cmd_valid(cmd_valid),
        .cmd_ack  (cmd_ack),
        .frame_err(frame_err),
        .bad_cmd  (bad_cmd),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count pulse cycles on the falling edge. A pulse held too long shows up as extra counts.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (bad_cmd)   bc_cnt++;
        if (overrun)   ov_cnt++;
        if (busy)      busy_cnt++;
        if (!cmd_valid) vlow_cnt++;
        if ((int'(frame_err) + int'(bad_cmd) + int'(overrun)) > 1) multi_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        fe0   = fe_cnt;
        bc0   = bc_cnt;
        ov0   = ov_cnt;
        busy0 = busy_cnt;
        vlow0 = vlow_cnt;
    endtask

    task automatic ack_pulse();
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
    endtask

    // Drive one frame. Step n is 1 ns after edge k+n, where edge k is the last edge before the start bit.
    // ack_n raises cmd_ack for the edge k+ack_n+1. At step abort_n the task asserts reset and returns.
    // rise reports the first step at which cmd_valid is seen high.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int ack_n, input int abort_n, output int rise_n);
        int b;
        rise_n = -1;
        for (int n = 0; n < 10 * CPB; n++) begin
            if (n == abort_n) begin
                rst = 1'b0;
                return;
            end
            b = n / CPB;
            if (b == 0) begin
                rx = 1'b0;
            end else if (b == 9) begin
                rx = stop_bit;
            end else begin
                rx = data[b-1];
            end
            if (n == ack_n) cmd_ack = 1'b1;
            else if (n == ack_n + 1) cmd_ack = 1'b0;
            if (rise_n < 0 && cmd_valid) rise_n = n;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b0;
        rx      = 1'b1;
        cmd_ack = 1'b0;
        tick(3);
        check_eq("rst_command",   32'(command),   32'd0);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_bad_cmd",   32'(bad_cmd),   32'd0);
        check_eq("rst_overrun",   32'(overrun),   32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        rst = 1'b1;
        tick(5);

        // 1: a good command is held until acked
        snap();
        send_frame(8'h05, 1'b1, -1, -1, rise);
        check_eq("t1_latency", 32'(rise), 32'd155);
        tick(10);
        check_eq("t1_command", 32'(command),   32'd5);
        check_eq("t1_valid",   32'(cmd_valid), 32'd1);
        check_eq("t1_flags",   32'(fe_cnt - fe0 + bc_cnt - bc0 + ov_cnt - ov0), 32'd0);
        ack_pulse();
        check_eq("t1_ack_clears", 32'(cmd_valid), 32'd0);
        tick(3);
        ack_pulse();
        check_eq("t1_idle_ack", 32'(cmd_valid), 32'd0);

        // 2: a malformed byte is discarded
        snap();
        send_frame(8'h25, 1'b1, -1, -1, rise);
        tick(10);
        check_eq("t2_bad_cmd", 32'(bc_cnt - bc0), 32'd1);
        check_eq("t2_valid",   32'(cmd_valid),    32'd0);
        check_eq("t2_command", 32'(command),      32'd5);
        check_eq("t2_other",   32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        // 3: a start-bit glitch returns to IDLE silently
        snap();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(20);
        check_eq("t3_busy",       32'(busy),               32'd0);
        check_eq("t3_busy_width", 32'(busy_cnt - busy0),   32'(CPB / 2));
        check_eq("t3_flags", 32'(fe_cnt - fe0 + bc_cnt - bc0 + ov_cnt - ov0), 32'd0);
        check_eq("t3_valid",      32'(cmd_valid),          32'd0);
        send_frame(8'h03, 1'b1, -1, -1, rise);
        tick(2);
        check_eq("t3_command", 32'(command),   32'd3);
        check_eq("t3_valid2",  32'(cmd_valid), 32'd1);
        ack_pulse();

        // 4: framing error, then recovery once the line returns high
        snap();
        send_frame(8'h02, 1'b0, -1, -1, rise);
        tick(40);
        check_eq("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check_eq("t4_valid",     32'(cmd_valid),    32'd0);
        check_eq("t4_busy_wait", 32'(busy),         32'd1);
        check_eq("t4_other",     32'(bc_cnt - bc0 + ov_cnt - ov0), 32'd0);
        rx = 1'b1;
        tick(CPB);
        check_eq("t4_busy_idle", 32'(busy), 32'd0);
        send_frame(8'h06, 1'b1, -1, -1, rise);
        tick(2);
        check_eq("t4_command", 32'(command),   32'd6);
        check_eq("t4_valid2",  32'(cmd_valid), 32'd1);
        ack_pulse();

        // 5a: back-to-back frames with no ack, so the second frame overruns
        snap();
        send_frame(8'h01, 1'b1, -1, -1, rise);
        send_frame(8'h04, 1'b1, -1, -1, rise);
        tick(2);
        check_eq("t5_command", 32'(command),      32'd1);
        check_eq("t5_valid",   32'(cmd_valid),    32'd1);
        check_eq("t5_overrun", 32'(ov_cnt - ov0), 32'd1);
        ack_pulse();
        tick(2);

        // 5b: an ack that coincides with the second stop sample reloads with no gap
        snap();
        send_frame(8'h01, 1'b1, -1, -1, rise);
        vlow0 = vlow_cnt;
        send_frame(8'h04, 1'b1, 154, -1, rise);
        tick(2);
        check_eq("t5b_command", 32'(command),          32'd4);
        check_eq("t5b_valid",   32'(cmd_valid),        32'd1);
        check_eq("t5b_overrun", 32'(ov_cnt - ov0),     32'd0);
        check_eq("t5b_no_gap",  32'(vlow_cnt - vlow0), 32'd0);
        ack_pulse();
        tick(2);

        // 6: reset in the middle of the data bits
        send_frame(8'h07, 1'b1, -1, 60, rise);
        #1;
        check_eq("t6_command", 32'(command),   32'd0);
        check_eq("t6_valid",   32'(cmd_valid), 32'd0);
        check_eq("t6_busy",    32'(busy),      32'd0);
        check_eq("t6_pulses",  32'({frame_err, bad_cmd, overrun}), 32'd0);
        tick(3);
        rx  = 1'b1;
        rst = 1'b1;
        tick(5);
        send_frame(8'h07, 1'b1, -1, -1, rise);
        tick(2);
        check_eq("t6_command2", 32'(command),   32'd7);
        check_eq("t6_valid2",   32'(cmd_valid), 32'd1);

        check_eq("pulse_exclusive", 32'(multi_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
